// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// Control bundle matches the stage-register enables and flushes.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic memwb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL = '{
    pc_write: 1'b1, ifid_write: 1'b1,
    ifid_flush: 1'b0, idex_write: 1'b1,
    idex_flush: 1'b0, exmem_write: 1'b1,
    memwb_bubble: 1'b0
  };

  localparam ctrl_t CTRL_BRANCH = '{
    pc_write: 1'b1, ifid_write: 1'b1,
    ifid_flush: 1'b1, idex_write: 1'b1,
    idex_flush: 1'b1, exmem_write: 1'b1,
    memwb_bubble: 1'b0
  };

  localparam ctrl_t CTRL_LOAD_USE = '{
    pc_write: 1'b0, ifid_write: 1'b0,
    ifid_flush: 1'b0, idex_write: 1'b1,
    idex_flush: 1'b1, exmem_write: 1'b1,
    memwb_bubble: 1'b0
  };

  localparam ctrl_t CTRL_FREEZE = '{
    pc_write: 1'b0, ifid_write: 1'b0,
    ifid_flush: 1'b0, idex_write: 1'b0,
    idex_flush: 1'b0, exmem_write: 1'b0,
    memwb_bubble: 1'b1
  };

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stage controls out.
// master = pipeline side, slave = controller.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             idex_mem_read;
  logic [REG_W-1:0] idex_rt;
  logic             branch_taken;
  logic             exmem_access;
  logic             dmem_ack;
  logic             dmem_req;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_flush;
  logic             exmem_write;
  logic             memwb_bubble;
  logic             bus_error;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, idex_mem_read,
    output idex_rt, branch_taken,
    output exmem_access, dmem_ack,
    input  dmem_req, pc_write,
    input  ifid_write, ifid_flush,
    input  idex_write, idex_flush,
    input  exmem_write, memwb_bubble,
    input  bus_error, stall_count
  );

  modport slave (
    input  id_rs, id_rt, idex_mem_read,
    input  idex_rt, branch_taken,
    input  exmem_access, dmem_ack,
    output dmem_req, pc_write,
    output ifid_write, ifid_flush,
    output idex_write, idex_flush,
    output exmem_write, memwb_bubble,
    output bus_error, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use compare: a load in EX whose destination is read in ID.
// Register zero never carries a dependency.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             idex_mem_read_i,
  input  logic [REG_W-1:0] idex_rt_i,
  output logic             hazard_o
);
  logic dst_live;
  logic src_match;

  assign dst_live  = idex_rt_i != REG_W'(REG_ZERO);
  assign src_match = (idex_rt_i == id_rs_i) |
                     (idex_rt_i == id_rt_i);
  assign hazard_o  = idex_mem_read_i & dst_live & src_match;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use, branch flush, dmem handshake.
// Outputs are forced low while rst is asserted.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter int REG_W       = 5
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int WC_W = $clog2(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST =
    WC_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  ctrl_t            ctrl;
  logic             req;
  logic             berr;
  logic             lu_hazard;
  logic             acked;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_lud (
    .id_rs_i         (hz.id_rs),
    .id_rt_i         (hz.id_rt),
    .idex_mem_read_i (hz.idex_mem_read),
    .idex_rt_i       (hz.idex_rt),
    .hazard_o        (lu_hazard)
  );

  assign acked = hz.exmem_access & hz.dmem_ack;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ctrl    = CTRL_FREEZE;
    req     = 1'b0;
    berr    = 1'b0;
    unique case (state_q)
      RUN: begin
        req = hz.exmem_access;
        if (hz.exmem_access && !hz.dmem_ack) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end else if (hz.branch_taken) begin
          ctrl = CTRL_BRANCH;
        end else if (lu_hazard) begin
          ctrl = CTRL_LOAD_USE;
        end else begin
          ctrl = CTRL_NORMAL;
        end
      end
      MEM_WAIT: begin
        req = hz.exmem_access;
        if (acked) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WC_LAST) begin
          state_d = ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ERROR: berr = 1'b1;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (!ctrl.pc_write && stall_q != '1)
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  // Reset gating makes a mid-wait reset drop dmem_req at once.
  assign hz.dmem_req     = rst & req;
  assign hz.pc_write     = rst & ctrl.pc_write;
  assign hz.ifid_write   = rst & ctrl.ifid_write;
  assign hz.ifid_flush   = rst & ctrl.ifid_flush;
  assign hz.idex_write   = rst & ctrl.idex_write;
  assign hz.idex_flush   = rst & ctrl.idex_flush;
  assign hz.exmem_write  = rst & ctrl.exmem_write;
  assign hz.memwb_bubble = rst & ctrl.memwb_bubble;
  assign hz.bus_error    = rst & berr;
  assign hz.stall_count  = stall_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench: directed scenarios with literal checks, then random
// traffic compared every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int T   = 4;
  localparam int CW  = 32;
  localparam int RW  = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_W(RW), .CNT_W(CW)) hz ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (T),
    .CNT_W       (CW),
    .REG_W       (RW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  task automatic check(string nm, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d want=%0d",
               nm, $time, act, exp);
    end
  endtask

  // Model: 0=running, 1=waiting on memory, 2=dead bus
  int     m_mode  = 0;
  int     m_wait  = 0;
  longint m_stall = 0;

  // {req,pcw,ifw,iff,idw,idf,exw,bub,berr}
  function automatic logic [8:0] expect_now();
    logic lu;
    logic hold;
    if (!rst) return 9'b0;
    if (m_mode == 2) return 9'b0_0000_0011;
    lu = hz.idex_mem_read && hz.idex_rt != 0 &&
         (hz.idex_rt == hz.id_rs ||
          hz.idex_rt == hz.id_rt);
    hold = (m_mode == 1) ||
           (hz.exmem_access && !hz.dmem_ack);
    if (hold)
      return {hz.exmem_access, 8'b0000_0010};
    if (hz.branch_taken)
      return {hz.exmem_access, 8'b1111_1100};
    if (lu)
      return {hz.exmem_access, 8'b0001_1100};
    return {hz.exmem_access, 8'b1101_0100};
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [8:0] e;
    if (!rst) begin
      m_mode = 0; m_wait = 0; m_stall = 0;
    end else begin
      e = expect_now();
      if (!e[7] && m_stall < (64'sd1 << CW) - 1)
        m_stall = m_stall + 1;
      if (m_mode == 0) begin
        if (hz.exmem_access && !hz.dmem_ack) begin
          m_mode = 1; m_wait = 0;
        end
      end else if (m_mode == 1) begin
        if (hz.exmem_access && hz.dmem_ack) begin
          m_mode = 0; m_wait = 0;
        end else if (m_wait == T - 1) begin
          m_mode = 2;
        end else begin
          m_wait = m_wait + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    e = expect_now();
    check("dmem_req",     hz.dmem_req,     e[8]);
    check("pc_write",     hz.pc_write,     e[7]);
    check("ifid_write",   hz.ifid_write,   e[6]);
    check("ifid_flush",   hz.ifid_flush,   e[5]);
    check("idex_write",   hz.idex_write,   e[4]);
    check("idex_flush",   hz.idex_flush,   e[3]);
    check("exmem_write",  hz.exmem_write,  e[2]);
    check("memwb_bubble", hz.memwb_bubble, e[1]);
    check("bus_error",    hz.bus_error,    e[0]);
    check("stall_count",  hz.stall_count,  m_stall);
  end

  task automatic idle();
    hz.id_rs = '0; hz.id_rt = '0;
    hz.idex_mem_read = 1'b0; hz.idex_rt = '0;
    hz.branch_taken = 1'b0;
    hz.exmem_access = 1'b0; hz.dmem_ack = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  longint base;
  int     nreq, nbub;

  initial begin
    idle();
    hz.exmem_access = 1'b1;
    #2;
    check("rst_req", hz.dmem_req, 0);
    check("rst_cnt", hz.stall_count, 0);
    check("rst_pcw", hz.pc_write, 0);
    cyc(); cyc();
    idle();
    rst = 1'b1;
    cyc();

    // 1: load-use stall, one bubble
    base = hz.stall_count;
    hz.idex_mem_read = 1'b1;
    hz.idex_rt = 5'd8; hz.id_rs = 5'd8;
    #1;
    check("lu_pcw", hz.pc_write, 0);
    check("lu_idf", hz.idex_flush, 1);
    cyc();
    idle();
    #1;
    check("lu_pcw_after", hz.pc_write, 1);
    cyc();
    check("lu_cnt", hz.stall_count - base, 1);

    // 2: r0 never hazards; branch wins over load-use
    hz.idex_mem_read = 1'b1;
    hz.idex_rt = 5'd0; hz.id_rs = 5'd0;
    #1;
    check("r0_pcw", hz.pc_write, 1);
    hz.idex_rt = 5'd3; hz.id_rt = 5'd3;
    hz.branch_taken = 1'b1;
    #1;
    check("br_pcw", hz.pc_write, 1);
    check("br_iff", hz.ifid_flush, 1);
    check("br_idf", hz.idex_flush, 1);
    cyc();
    idle();

    // 3: ack after 3 cycles -> 4 frozen cycles
    base = hz.stall_count;
    nreq = 0; nbub = 0;
    hz.exmem_access = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hz.dmem_ack = (i == 3);
      #1;
      nreq += hz.dmem_req;
      nbub += hz.memwb_bubble;
      cyc();
    end
    idle();
    #1;
    check("mw_req_cyc", nreq, 4);
    check("mw_bub_cyc", nbub, 4);
    check("mw_cnt", hz.stall_count - base, 4);
    check("mw_run", hz.pc_write, 1);
    cyc();

    // 4: zero-wait ack
    base = hz.stall_count;
    hz.exmem_access = 1'b1; hz.dmem_ack = 1'b1;
    #1;
    check("zw_pcw", hz.pc_write, 1);
    check("zw_bub", hz.memwb_bubble, 0);
    cyc();
    idle();
    check("zw_cnt", hz.stall_count - base, 0);

    // 5: branch held in EX across a wait
    hz.branch_taken = 1'b1;
    hz.exmem_access = 1'b1;
    nbub = 0;
    for (int i = 0; i < 3; i++) begin
      hz.dmem_ack = (i == 2);
      #1;
      nbub += hz.ifid_flush + hz.idex_flush;
      cyc();
    end
    hz.exmem_access = 1'b0; hz.dmem_ack = 1'b0;
    #1;
    check("bw_noflush", nbub, 0);
    check("bw_iff", hz.ifid_flush, 1);
    check("bw_idf", hz.idex_flush, 1);
    cyc();
    idle();

    // reset mid-wait drops dmem_req immediately
    hz.exmem_access = 1'b1;
    cyc(); cyc();
    #1;
    check("mid_req", hz.dmem_req, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_req", hz.dmem_req, 0);
    cyc();
    rst = 1'b1;
    cyc();

    // 6: timeout -> sticky error, then async reset
    hz.exmem_access = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    check("to_berr", hz.bus_error, 1);
    check("to_req", hz.dmem_req, 0);
    hz.dmem_ack = 1'b1;
    cyc(); cyc();
    check("to_sticky", hz.bus_error, 1);
    #2;
    rst = 1'b0;
    #1;
    check("to_rst_berr", hz.bus_error, 0);
    check("to_rst_cnt", hz.stall_count, 0);
    idle();
    cyc();
    rst = 1'b1;
    cyc();
    check("to_rel_pcw", hz.pc_write, 1);
    check("to_rel_cnt", hz.stall_count, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 59) != 0);
      hz.id_rs = RW'($urandom_range(0, 3));
      hz.id_rt = RW'($urandom_range(0, 3));
      hz.idex_rt = RW'($urandom_range(0, 3));
      hz.idex_mem_read = ($urandom_range(0, 2) == 0);
      hz.branch_taken = ($urandom_range(0, 6) == 0);
      hz.exmem_access = ($urandom_range(0, 2) == 0);
      hz.dmem_ack = ($urandom_range(0, 4) < 2);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
